// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES round count, FSM encoding and GF(2^8) helpers
// AES_KEY256_EN selects 14 rounds (AES-256); otherwise 10 rounds (AES-128).
package aes_pkg;

  localparam int CNT_W = 4;

`ifdef AES_KEY256_EN
  localparam logic [CNT_W-1:0] NR = 4'd14;
`else
  localparam logic [CNT_W-1:0] NR = 4'd10;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse computed as a^254 (0 maps to 0), followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// rtl/aes_add_round_key.sv - AddRoundKey: State xor round key
module aes_add_round_key (
  input  logic [127:0] din,
  input  logic [127:0] rk,
  output logic [127:0] dout
);

  assign dout = din ^ rk;

endmodule

// File: rtl/aes_mix_columns.sv
// rtl/aes_mix_columns.sv - MixColumns: each column multiplied by {02 03 01 01} circulant
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[32*c      +: 8];
    assign a1 = din[32*c + 8  +: 8];
    assign a2 = din[32*c + 16 +: 8];
    assign a3 = din[32*c + 24 +: 8];

    assign dout[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign dout[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign dout[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign dout[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round; MixColumns skipped on the final round
module aes_round (
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_round_i,
  output logic [127:0] state_o
);

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] mc_sel;

  aes_sub_bytes u_sub_bytes (
    .din  (state_i),
    .dout (sb)
  );

  aes_shift_rows u_shift_rows (
    .din  (sb),
    .dout (sr)
  );

  aes_mix_columns u_mix_columns (
    .din  (sr),
    .dout (mc)
  );

  assign mc_sel = final_round_i ? sr : mc;

  aes_add_round_key u_add_round_key (
    .din  (mc_sel),
    .rk   (rk_i),
    .dout (state_o)
  );

endmodule

// File: rtl/aes_shift_rows.sv
// rtl/aes_shift_rows.sv - ShiftRows: row r rotated left by r columns
module aes_shift_rows (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  // Byte index is 4*column + row
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout[8*(4*c+r) +: 8] = din[8*(4*((c+r)%4)+r) +: 8];
    end
  end

endmodule

// File: rtl/aes_sub_bytes.sv
// rtl/aes_sub_bytes.sv - SubBytes: byte-wise S-box over the 128-bit State
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES encryption sequencer, one round per clock
// Round count follows AES_KEY256_EN (14 when defined, 10 otherwise); ports identical in both builds.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic [3:0]       rk_idx,
  input  logic [127:0]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       st_q, st_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [127:0]       out_data_q, out_data_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [127:0]       round_out;
  logic               final_round;

  assign final_round = (cnt_q == NR);

  // The key store is only addressed by the counter while rounds are running
  assign rk_idx = (state_q == ST_ROUND) ? cnt_q : '0;

  aes_round u_round (
    .state_i       (st_q),
    .rk_i          (rk_data),
    .final_round_i (final_round),
    .state_o       (round_out)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    st_d       = st_q;
    tag_d      = tag_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid && in_ready) begin
          st_d    = in_data ^ rk_data;
          tag_d   = in_tag;
          cnt_d   = 4'd1;
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        st_d = round_out;
        if (final_round) begin
          out_data_d = round_out;
          out_tag_d  = tag_q;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      st_q       <= '0;
      tag_q      <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      st_q       <= st_d;
      tag_q      <= tag_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign out_data = out_data_q;
  assign out_tag  = out_tag_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl: FIPS-197 C.1, or C.3 when AES_KEY256_EN is defined
module tb_aes_round_ctrl;

  localparam int TAG_W = 4;
`ifdef AES_KEY256_EN
  localparam int NR = 14;
  localparam int NK = 8;
  localparam logic [127:0] CT = 128'h8960494b9049fceabf456751cab7a28e;
`else
  localparam int NR = 10;
  localparam int NK = 4;
  localparam logic [127:0] CT = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
`endif
  localparam logic [127:0] PT = 128'hffeeddccbbaa99887766554433221100;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [127:0]     data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic [3:0]       rk_idx;
  logic [127:0]     rk_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  logic [127:0] rk_tab [0:15];
  logic [31:0]  w [0:59];
  logic [31:0]  t;
  logic [7:0]   rc;

  exp_t sb_q[$];
  int   acc_cyc[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   n;

  always #5 clk = ~clk;

  assign rk_data = rk_tab[rk_idx];

  aes_round_ctrl #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  // One clock: record handshakes seen at this negedge, then advance to the next negedge
  task automatic tick();
    logic acc;
    logic ohs;
    exp_t e;
    acc = in_valid && in_ready;
    ohs = out_valid && out_ready;
    check("rk_idx_range", 128'(int'(rk_idx) <= NR), 128'd1);
    if (acc) begin
      e.tag  = in_tag;
      e.data = CT;
      sb_q.push_back(e);
      acc_cyc.push_back(cyc);
    end
    if (ohs) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 128'(out_valid), 128'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_out_data", out_data, e.data);
        check("sb_out_tag", 128'(out_tag), 128'(e.tag));
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_out(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    check(name, 128'(out_valid), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NK; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rc = 8'h01;
    for (int i = NK; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (NK > 6 && i % NK == 4) begin
        t = subword(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r <= NR; r++)
      for (int b = 0; b < 16; b++)
        rk_tab[r][8*b +: 8] = w[4*r + b/4][31-8*(b%4) -: 8];

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_out_tag", 128'(out_tag), 128'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 vector, latency and rk_idx sequence
    in_valid = 1'b1; in_data = PT; in_tag = 4'h5;
    check("rk_idx_accept", 128'(rk_idx), 128'd0);
    tick();
    in_valid = 1'b0; in_data = '0;
    for (int k = 1; k <= NR; k++) begin
      check("rk_idx_round", 128'(rk_idx), 128'(k));
      check("no_early_valid", 128'(out_valid), 128'd0);
      check("in_ready_round", 128'(in_ready), 128'd0);
      tick();
    end
    check("latency_valid", 128'(out_valid), 128'd1);
    check("rk_idx_done", 128'(rk_idx), 128'd0);
    check("busy_done", 128'(busy), 128'd1);
    check("c1_out_data", out_data, CT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_out", 128'(in_ready), 128'd1);
    check("valid_drop", 128'(out_valid), 128'd0);
    check("rk_idx_idle", 128'(rk_idx), 128'd0);

    // Backpressure: output held for 7 cycles
    in_valid = 1'b1; in_data = PT; in_tag = 4'h3;
    tick();
    in_valid = 1'b0;
    wait_out("bp_wait");
    for (int k = 0; k < 7; k++) begin
      check("bp_data", out_data, CT);
      check("bp_tag", 128'(out_tag), 128'h3);
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", 128'(in_ready), 128'd1);
    check("bp_idle_busy", 128'(busy), 128'd0);

    // Back-to-back with in_valid held high
    acc_cyc.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = PT; in_tag = 4'h6;
    n = 0;
    while (acc_cyc.size() < 2 && n < 60) begin
      tick();
      n++;
      if (acc_cyc.size() == 1) in_tag = 4'h7;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(acc_cyc.size()), 128'd2);
    if (acc_cyc.size() == 2) check("b2b_interval", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NR + 2));
    n = 0;
    while (sb_q.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    check("b2b_drain", 128'(sb_q.size()), 128'd0);
    out_ready = 1'b0;

    // Reset during round 5
    in_valid = 1'b1; in_data = PT; in_tag = 4'h4;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("mid_rk5", 128'(rk_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_data", out_data, 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_ready", 128'(in_ready), 128'd0);
    check("mid_rst_rk_idx", 128'(rk_idx), 128'd0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b1; in_data = PT; in_tag = 4'h5;
    tick();
    in_valid = 1'b0;
    wait_out("post_rst_wait");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sb_empty_end", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES encryption sequencer. It accepts one 128-bit plaintext block over a valid/ready handshake and holds the State in a register. It applies one full round per clock through a combinational round datapath built from the existing SubBytes, ShiftRows, MixColumns and AddRoundKey blocks, then returns ciphertext over a valid/ready handshake. Round keys come from an external key store, addressed by round index and read combinationally in the same cycle.

Parameters:
TAG_W, 4, width of a user tag carried unchanged from input block to output block.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  plaintext block offered
in_ready  output  1  block accepted when in_valid && in_ready
in_data  input  128  plaintext; State byte bN at bits [8N+7:8N], column-major (b0..b3 = column 0)
in_tag  input  TAG_W  user tag
rk_idx  output  4  round-key index requested this cycle
rk_data  input  128  round key for rk_idx, same byte layout, valid same cycle
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts when out_valid && out_ready
out_data  output  128  ciphertext, same byte layout
out_tag  output  TAG_W  tag of this block
busy  output  1  high in ROUND or DONE

Behaviour:
- Nr = 10 by default; 14 with the optional feature.
- FSM states: IDLE, ROUND, DONE.
- Reset (async, rst_n low): state goes to IDLE; State reg, out_data, out_tag, round counter and rk_idx are all 0. out_valid=0, in_ready=0 while rst_n is low, busy=0. Reset mid-operation aborts the block silently; no partial output appears.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On accept: State <= in_data ^ rk_data (initial AddRoundKey), tag captured, round counter <= 1, go to ROUND.
- ROUND:
  - in_ready=0, rk_idx = round counter.
  - Each cycle: State <= round(State, rk_data), where round = SubBytes → ShiftRows → MixColumns → AddRoundKey.
  - When counter == Nr, MixColumns is bypassed (final round), the result is loaded into out_data, and the FSM goes to DONE.
  - Otherwise the counter increments.
- DONE:
  - out_valid=1; out_data and out_tag are held stable until out_ready.
  - On handshake: go to IDLE, out_valid=0 the next cycle.
  - in_ready stays 0 in DONE; no skid, one block in flight.
- Latency: accept at edge T → out_valid high after edge T+Nr (10 cycles for AES-128). Minimum initiation interval is Nr+2 cycles when out_ready is held high.
- in_valid held high during ROUND/DONE is ignored; the block is taken on the next IDLE cycle.
- rk_idx never exceeds Nr; the round counter does not wrap.
- out_ready while out_valid=0 has no effect.

Optional Feature:
Macro AES_KEY256_EN.
- Defined: Nr=14 (AES-256). rk_idx spans 0..14. Latency is 14 cycles.
- Undefined: Nr=10 (AES-128). rk_idx spans 0..10.
- Ports and widths are identical in both builds.

Decomposition:
- Shared package/header aes_pkg: NR constant (selected by AES_KEY256_EN), FSM state encodings, round-counter width (4).
- One natural sub-module, aes_round: combinational; inputs State, round key, final_round flag; output next State. It instantiates the existing SubBytes, ShiftRows, MixColumns and AddRoundKey modules.
- aes_round_ctrl holds the FSM, counter, State and tag registers, and the handshakes.

Test Plan:
- FIPS-197 C.1 (AES-128):
  - Stimulus: key 000102..0f, bench key model drives rk_data from rk_idx, in_data=128'hffeeddccbbaa99887766554433221100, tag 4'h5.
  - Required: out_valid exactly 10 cycles after accept, out_data=128'h5ac5b47080b7cdd830047b6ad8e0c469, out_tag=4'h5.
- Backpressure:
  - Stimulus: hold out_ready=0 for 7 cycles after out_valid rises.
  - Required: out_data/out_tag stable, in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Back-to-back:
  - Stimulus: in_valid held high with two blocks, out_ready=1.
  - Required: second accept occurs 12 cycles after the first; both ciphertexts correct and in order.
- Reset mid-operation:
  - Stimulus: drop rst_n at round 5.
  - Required: out_valid=0, out_data=0, busy=0 immediately. After release, in_ready=1 and a fresh C.1 block produces the correct result.
- rk_idx sequence:
  - Required: 0 at accept, then 1..10 one per cycle, then 0 in DONE/IDLE.
- AES_KEY256_EN build, FIPS-197 C.3:
  - Stimulus: key 00..1f, same in_data as C.1.
  - Required: 14-cycle latency, out_data=128'h8960494b9049fceabf456751cab7a28e.
